// File: rtl/irq_request_reg_if.sv
// irq_request_reg_if: request, control and arbitration-result signals of irq_request_reg
interface irq_request_reg_if #(
  parameter int NUM_CH = 8,
  parameter int IDX_W = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0] interrupt_Requests;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] IRR_Output;
  logic ltim;
  logic rotate_en;
  logic ack;
  logic int_req;
  logic [IDX_W-1:0] int_id;
  modport master (
    output interrupt_Requests, mask, ltim, rotate_en, ack,
    input IRR_Output, int_req, int_id
  );
  modport slave (
    input interrupt_Requests, mask, ltim, rotate_en, ack,
    output IRR_Output, int_req, int_id
  );
endinterface

// File: rtl/irq_request_reg.sv
// irq_request_reg: pending-request register with edge/level capture and fixed/rotating arbitration
module irq_request_reg #(
  parameter int NUM_CH = 8,
  parameter int IDX_W = $clog2(NUM_CH)
) (
  input logic clk,
  input logic rst,
  irq_request_reg_if.slave bus
);
  logic [NUM_CH-1:0] prev_q, irr_q, irr_d, elig, rot, clr;
  logic int_req_q, int_req_d, acc;
  logic [IDX_W-1:0] int_id_q, int_id_d, base_q, base_d, start, off;
  logic [IDX_W:0] sum;
  assign acc = bus.ack & int_req_q;
  assign clr = acc ? NUM_CH'(1) << int_id_q : '0;
  assign irr_d = (bus.interrupt_Requests & ~prev_q)
               | ((bus.ltim ? bus.interrupt_Requests : bus.interrupt_Requests & irr_q) & ~clr);
  assign elig = irr_q & ~bus.mask;
  assign start = bus.rotate_en ? base_q : '0;
  assign rot = NUM_CH'({elig, elig} >> start);
  // offset from start of the first eligible channel
  always_comb begin
    off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) off = rot[k] ? IDX_W'(k) : off;
  end
  assign sum = {1'b0, start} + {1'b0, off};
  assign int_id_d = acc ? int_id_q
                  : (sum >= (IDX_W+1)'(NUM_CH) ? IDX_W'(sum - (IDX_W+1)'(NUM_CH)) : sum[IDX_W-1:0]);
  assign int_req_d = ~acc & (|elig);
  assign base_d = (acc & bus.rotate_en) ? (int_id_q == IDX_W'(NUM_CH - 1) ? '0 : int_id_q + 1'b1) : base_q;
  // state update; prev tracks the inputs even during reset so held lines are not seen as edges
  always_ff @(posedge clk) begin
    prev_q <= bus.interrupt_Requests;
    if (rst) begin
      irr_q <= '0;
      int_req_q <= 1'b0;
      int_id_q <= '0;
      base_q <= '0;
    end else begin
      irr_q <= irr_d;
      int_req_q <= int_req_d;
      int_id_q <= int_id_d;
      base_q <= base_d;
    end
  end
  assign bus.IRR_Output = irr_q;
  assign bus.int_req = int_req_q;
  assign bus.int_id = int_id_q;
endmodule

// File: tb/tb_irq_request_reg.sv
// tb_irq_request_reg: directed vector table plus randomized comparison against a behavioural model
module tb_irq_request_reg;
  localparam int N = 8;
  typedef struct {
    logic r, l, ro, a;
    logic [N-1:0] rq, mk, e_irr;
    logic e_rq;
    int e_id;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  irq_request_reg_if #(.NUM_CH(N)) bus();
  irq_request_reg #(.NUM_CH(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  logic [N-1:0] m_prev, m_irr;
  logic m_rq;
  int m_id, m_base;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, l, ro, a, input logic [N-1:0] rq, mk);
    logic acc;
    logic [N-1:0] n;
    int start, ch;
    rst = r; bus.ltim = l; bus.rotate_en = ro; bus.ack = a;
    bus.interrupt_Requests = rq; bus.mask = mk;
    @(posedge clk);
    if (r) begin
      m_irr = '0; m_rq = 1'b0; m_id = 0; m_base = 0;
    end else begin
      acc = a && m_rq;
      for (int i = 0; i < N; i++)
        n[i] = (rq[i] && !m_prev[i]) || ((l ? rq[i] : (rq[i] && m_irr[i])) && !(acc && i == m_id));
      if (acc) begin
        m_rq = 1'b0;
        if (ro) m_base = (m_id + 1) % N;
      end else begin
        m_rq = 1'b0;
        start = ro ? m_base : 0;
        for (int k = N - 1; k >= 0; k--) begin
          ch = (start + k) % N;
          if (m_irr[ch] && !mk[ch]) begin
            m_rq = 1'b1;
            m_id = ch;
          end
        end
      end
      m_irr = n;
    end
    m_prev = rq;
    #1;
  endtask

  task automatic add(input logic r, l, ro, a, input logic [N-1:0] rq, mk, e_irr, input logic e_rq, input int e_id);
    vec_t v;
    v.r = r; v.l = l; v.ro = ro; v.a = a; v.rq = rq; v.mk = mk;
    v.e_irr = e_irr; v.e_rq = e_rq; v.e_id = e_id;
    tbl.push_back(v);
  endtask

  initial begin
    logic r, l, ro, a;
    logic [N-1:0] rq, mk;
    //   r  l  ro a  req    mask   irr    rq id
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h04, 8'h00, 8'h04, 0, 0);
    add(0, 0, 0, 0, 8'h04, 8'h00, 8'h04, 1, 2);
    add(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h28, 8'h08, 8'h28, 0, 0);
    add(0, 0, 0, 0, 8'h28, 8'h08, 8'h28, 1, 5);
    add(0, 0, 0, 1, 8'h28, 8'h08, 8'h08, 0, 0);
    add(0, 0, 0, 0, 8'h28, 8'h08, 8'h08, 0, 0);
    add(0, 0, 0, 0, 8'h28, 8'h08, 8'h08, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 3);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h02, 8'h00, 8'h02, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 1, 8'hFF, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h08, 8'h00, 8'h08, 0, 0);
    add(0, 1, 0, 0, 8'h08, 8'h00, 8'h08, 1, 3);
    add(0, 1, 0, 1, 8'h08, 8'h00, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h08, 8'h00, 8'h08, 0, 0);
    add(0, 1, 0, 0, 8'h08, 8'h00, 8'h08, 1, 3);
    add(0, 1, 1, 0, 8'h81, 8'h00, 8'h81, 1, 3);
    add(0, 1, 1, 0, 8'h81, 8'h00, 8'h81, 1, 0);
    add(0, 1, 1, 1, 8'h81, 8'h00, 8'h80, 0, 0);
    add(0, 1, 1, 0, 8'h81, 8'h00, 8'h81, 1, 7);
    add(0, 1, 1, 0, 8'h81, 8'h00, 8'h81, 1, 7);
    add(0, 1, 1, 1, 8'h81, 8'h00, 8'h01, 0, 0);
    add(0, 1, 1, 0, 8'h81, 8'h00, 8'h81, 1, 0);
    add(0, 1, 1, 0, 8'h81, 8'h00, 8'h81, 1, 0);
    add(0, 0, 0, 0, 8'h01, 8'h00, 8'h01, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0);
    add(0, 0, 0, 1, 8'h01, 8'h00, 8'h01, 0, 0);
    add(0, 0, 0, 0, 8'h01, 8'h00, 8'h01, 1, 0);
    add(1, 0, 0, 1, 8'h01, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0);
    step(1, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, '0, '0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].ro, tbl[i].a, tbl[i].rq, tbl[i].mk);
      chk($sformatf("row%0d_irr", i), int'(bus.IRR_Output), int'(tbl[i].e_irr));
      chk($sformatf("row%0d_int_req", i), int'(bus.int_req), int'(tbl[i].e_rq));
      if (tbl[i].e_rq) chk($sformatf("row%0d_int_id", i), int'(bus.int_id), tbl[i].e_id);
    end
    l = 1'b0; ro = 1'b0; rq = '0; mk = '0;
    for (int c = 0; c < 600; c++) begin
      r = (c < 2) || ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) l = ~l;
      if ($urandom_range(0, 29) == 0) ro = ~ro;
      a = ($urandom_range(0, 2) == 0);
      rq ^= N'($urandom) & N'($urandom);
      if ($urandom_range(0, 7) == 0) mk = N'($urandom) & N'($urandom);
      step(r, l, ro, a, rq, mk);
      chk($sformatf("rand%0d_irr", c), int'(bus.IRR_Output), int'(m_irr));
      chk($sformatf("rand%0d_int_req", c), int'(bus.int_req), int'(m_rq));
      if (m_rq) chk($sformatf("rand%0d_int_id", c), int'(bus.int_id), m_id);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/irq_request_reg.md
IRQ_REQUEST_REG -- requirements
Module: irq_request_reg

Interface
REQ-001 Parameter NUM_CH, 8, number of interrupt request channels (2..32).
REQ-002 Parameter IDX_W, $clog2(NUM_CH), width of the channel index output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 interrupt_Requests  input  NUM_CH  raw request lines, bit i = channel i.
REQ-006 ltim  input  1  trigger mode: 0 = edge, 1 = level (global, all channels).
REQ-007 mask  input  NUM_CH  per-channel mask; 1 = channel excluded from arbitration.
REQ-008 rotate_en  input  1  0 = fixed priority, 1 = rotating priority.
REQ-009 ack  input  1  one-cycle acknowledge pulse for the currently reported channel.
REQ-010 IRR_Output  output  NUM_CH  registered pending-request vector.
REQ-011 int_req  output  1  registered; 1 = an unmasked request is pending.
REQ-012 int_id  output  IDX_W  registered index of the winning channel; valid only while int_req = 1.

Function
REQ-013 An internal prev register SHALL capture interrupt_Requests every cycle, including reset cycles.
REQ-014 Edge mode: bit i SHALL set on an edge where interrupt_Requests[i]=1 and prev[i]=0.
REQ-015 Edge mode: a set bit SHALL hold while interrupt_Requests[i]=1 and clear on the edge after interrupt_Requests[i] is sampled 0.
REQ-016 Level mode: bit i SHALL equal the sampled interrupt_Requests[i] each cycle, subject to REQ-018.
REQ-017 An accepted ack is ack=1 while int_req=1; ack while int_req=0 SHALL be ignored with no state change.
REQ-018 An accepted ack SHALL clear IRR_Output[int_id] at that edge; in level mode the bit re-sets on the next edge if the input is still high.
REQ-019 A set condition and an accepted ack on the same channel at the same edge SHALL resolve with set winning.
REQ-020 The eligible vector SHALL be IRR_Output & ~mask.
REQ-021 int_req and int_id SHALL be computed from the eligible vector and registered; latency input edge -> IRR_Output is 1 cycle, -> int_req is 2 cycles.
REQ-022 On an accepted ack, int_req SHALL be forced to 0 at that edge and re-evaluated on the following edge, so no double acknowledge is possible.
REQ-023 Fixed priority: the lowest eligible index SHALL win.
REQ-024 Rotating priority: the winner SHALL be the first eligible channel scanning upward from pointer base, wrapping NUM_CH-1 -> 0.
REQ-025 On each accepted ack, base SHALL become (acked id + 1) mod NUM_CH; base SHALL be held while rotate_en=0, and used unchanged when rotate_en changes.
REQ-026 Mask changes SHALL affect only arbitration, never IRR_Output contents.
REQ-027 A ltim change SHALL take effect on the next edge; IRR_Output SHALL not be cleared by the change.

Reset
REQ-028 While rst=1: IRR_Output=0, int_req=0, int_id=0, base=0; prev SHALL load interrupt_Requests.
REQ-029 A line held high through reset SHALL NOT register as an edge after release in edge mode; in level mode it appears on the first edge after release.
REQ-030 Reset asserted mid-operation SHALL override ack and all set conditions in that cycle.

Verification
REQ-031 Edge mode, NUM_CH=8, input 0x00 -> 0x04 held -> IRR_Output=0x04 after 1 cycle, int_req=1 and int_id=2 after 2 cycles.
REQ-032 Fixed priority, inputs 0x28, mask=0x08 -> int_id=5; ack -> IRR_Output=0x08, int_req=0 next cycle, then stays 0 (masked).
REQ-033 Rotating priority, level mode, inputs 0x81 held; ack on id 0 -> base=1, next int_id=7; ack -> base=0, next int_id=0.
REQ-034 Edge mode, 0x02 pulse high 1 cycle, then low -> IRR_Output bit 1 sets, then clears; no ack needed.
REQ-035 Input 0xFF held through rst deassertion, edge mode -> IRR_Output stays 0x00; ack while int_req=0 -> no change.
REQ-036 Level mode, channel 3 held high, ack -> bit 3 clears, re-sets next cycle, int_req reasserts with int_id=3 one cycle later.
